matrix_result_unloader: RTL and testbench

Output-side companion to the 2x2 matrix multiplier. Captures the four 16-bit products when `multiplication_done` rises, then streams them off-chip as bytes over a valid/ready handshake. It sits between the multiplier's result outputs and the chip's narrow output pins. It is the reader for the multiplier's result interface.

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/rise_detect.sv | 22 ++
 rtl/matrix_result_unloader.sv | 130 +++++++++++++
 tb/tb_matrix_result_unloader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared sizes and unloader state type; frame length depends on RESULT_CHECKSUM_EN
package matrix_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_OUT_W       = 8;
  localparam int DEF_NUM_RESULTS = 4;

  localparam int BYTES_PER_RESULT = DEF_DATA_W / DEF_OUT_W;
  localparam int DATA_BYTES       = DEF_NUM_RESULTS * BYTES_PER_RESULT;
`ifdef RESULT_CHECKSUM_EN
  localparam int FRAME_BYTES      = DATA_BYTES + 1;
`else
  localparam int FRAME_BYTES      = DATA_BYTES;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CHK
  } unload_state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-cycle rise pulse from a level input
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= level;
    end
  end

  // Cleared history after reset makes a still-high level count as a fresh rise.
  assign rise = level & ~done_q;

endmodule

// File: rtl/matrix_result_unloader.sv
// rtl/matrix_result_unloader.sv - captures the 2x2 product and streams it as bytes
// Optional checksum byte appended when RESULT_CHECKSUM_EN is defined.
module matrix_result_unloader
  import matrix_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int NUM_RESULTS = DEF_NUM_RESULTS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              multiplication_done,
  input  logic [DATA_W-1:0] result1,
  input  logic [DATA_W-1:0] result2,
  input  logic [DATA_W-1:0] result3,
  input  logic [DATA_W-1:0] result4,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int BPR    = DATA_W / OUT_W;
  localparam int DBYTES = NUM_RESULTS * BPR;
  localparam int IDX_W  = $clog2(DBYTES + 1);

  logic              rise;
  logic              xfer;
  unload_state_t     state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shadow [NUM_RESULTS];
  logic [OUT_W-1:0]  next_byte;
`ifdef RESULT_CHECKSUM_EN
  logic [OUT_W-1:0]  csum;
`endif

  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .level (multiplication_done),
    .rise  (rise)
  );

  assign xfer = out_valid & out_ready;

  // idx names the byte to present after the current one is taken; MSB first per word.
  always_comb begin
    next_byte = '0;
    for (int w = 0; w < NUM_RESULTS; w++) begin
      for (int b = 0; b < BPR; b++) begin
        if (idx == IDX_W'(w * BPR + b)) begin
          next_byte = shadow[w][DATA_W-1-b*OUT_W -: OUT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int w = 0; w < NUM_RESULTS; w++) begin
        shadow[w] <= '0;
      end
`ifdef RESULT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            shadow[0] <= result1;
            shadow[1] <= result2;
            shadow[2] <= result3;
            shadow[3] <= result4;
            idx       <= IDX_W'(1);
            state     <= SEND;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= 1'b0;
            // Shadow is not loaded yet this cycle, so byte 0 comes straight from the input.
            out_data  <= result1[DATA_W-1 -: OUT_W];
`ifdef RESULT_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        SEND, CHK: begin
          if (rise) begin
            overrun <= 1'b1;
          end
          if (xfer) begin
`ifdef RESULT_CHECKSUM_EN
            csum <= csum ^ out_data;
`endif
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end
`ifdef RESULT_CHECKSUM_EN
            else if (idx == IDX_W'(DBYTES)) begin
              state    <= CHK;
              out_data <= csum ^ out_data;
              out_last <= 1'b1;
            end
`endif
            else begin
              out_data <= next_byte;
              idx      <= idx + IDX_W'(1);
`ifndef RESULT_CHECKSUM_EN
              out_last <= (idx == IDX_W'(DBYTES - 1));
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_unloader.sv
// tb/tb_matrix_result_unloader.sv - scoreboard bench for matrix_result_unloader
module tb_matrix_result_unloader;

`ifdef RESULT_CHECKSUM_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        multiplication_done;
  logic [15:0] result1, result2, result3, result4;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overrun;

  logic [8:0]  q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        stall_prev = 1'b0;
  logic [8:0]  stall_val = '0;

  matrix_result_unloader dut (
    .clk                 (clk),
    .rst                 (rst),
    .multiplication_done (multiplication_done),
    .result1             (result1),
    .result2             (result2),
    .result3             (result3),
    .result4             (result4),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_last            (out_last),
    .busy                (busy),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: {last, byte} entries, optional XOR checksum at the end.
  task automatic push_frame(input logic [15:0] r1, input logic [15:0] r2,
                            input logic [15:0] r3, input logic [15:0] r4);
    logic [15:0] w[4];
    logic [7:0]  cs = 8'h00;
    logic [7:0]  by;
    logic        last;
    w[0] = r1; w[1] = r2; w[2] = r3; w[3] = r4;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 2; b++) begin
        by   = (b == 0) ? w[i][15:8] : w[i][7:0];
        cs   = cs ^ by;
        last = (FRAME == 8) && (i == 3) && (b == 1);
        q.push_back({last, by});
      end
    end
    if (FRAME == 9) q.push_back({1'b1, cs});
  endtask

  task automatic wait_drain(input string tag, input int exact);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_drained"}, q.size(), 0);
    if (exact > 0) check({tag, "_cycles"}, n, exact);
    @(negedge clk); #1;
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", {out_last, out_data}, stall_val);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_byte", {out_last, out_data}, 9'h1ff ^ {out_last, out_data});
        end else begin
          check("byte", {out_last, out_data}, q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_last, out_data};
    end
  end

  initial begin
    rst = 1'b1;
    multiplication_done = 1'b0;
    out_ready = 1'b1;
    result1 = 16'h1234; result2 = 16'hABCD; result3 = 16'h0001; result4 = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", out_data, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame with sink always ready
    push_frame(result1, result2, result3, result4);
    multiplication_done = 1'b1;
    @(negedge clk); #1;
    check("s1_valid_before_edge", out_valid, 1'b0);
    @(negedge clk); #1;
    check("s1_busy_first", busy, 1'b1);
    check("s1_first_valid", out_valid, 1'b1);
    wait_drain("s1", FRAME - 1);
    @(posedge clk); #1;
    multiplication_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure while byte 2 is presented
    push_frame(result1, result2, result3, result4);
    multiplication_done = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk); #1;
    check("s2_stall_data", out_data, 8'hAB);
    check("s2_stall_valid", out_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("s2", 0);
    check("s2_no_overrun", overrun, 1'b0);
    @(posedge clk); #1;
    multiplication_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Second rise during byte 4 with inputs zeroed
    push_frame(result1, result2, result3, result4);
    multiplication_done = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    multiplication_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    multiplication_done = 1'b1;
    result1 = 16'h0; result2 = 16'h0; result3 = 16'h0; result4 = 16'h0;
    wait_drain("s3", 0);
    check("s3_overrun", overrun, 1'b1);
    @(posedge clk); #1;
    multiplication_done = 1'b0;
    result1 = 16'h1234; result2 = 16'hABCD; result3 = 16'h0001; result4 = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;

    // Reset after byte 3 transfers, done kept high
    push_frame(result1, result2, result3, result4);
    multiplication_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("s4_remaining_before_rst", q.size(), FRAME - 4);
    rst = 1'b1;
    #1;
    check("s4_rst_valid", out_valid, 1'b0);
    check("s4_rst_busy", busy, 1'b0);
    check("s4_rst_overrun", overrun, 1'b0);
    q.delete();
    push_frame(result1, result2, result3, result4);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("s4_valid_before_edge", out_valid, 1'b0);
    wait_drain("s4", FRAME);

    // Long level produces a single frame
    @(posedge clk); #1;
    multiplication_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_frame(result1, result2, result3, result4);
    multiplication_done = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    multiplication_done = 1'b0;
    check("s5_drained", q.size(), 0);
    check("s5_valid", out_valid, 1'b0);
    check("s5_busy", busy, 1'b0);
    check("s5_overrun", overrun, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
